// File: rtl/hdlc_tx_sched_if.sv
// ============================================================================
// Module      : hdlc_tx_sched_if
// Description : Bundle between the two frame requesters and the HDLC transmit
//               scheduler. The requester side (master) raises req/data. The
//               scheduler side (slave) returns acks, the serializer load
//               strobe/frame and the RS-485 driver enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hdlc_tx_sched_if;
    logic        req0;
    logic [63:0] data0;
    logic        req1;
    logic [63:0] data1;
    logic        ack0;
    logic        ack1;
    logic        is_tran;
    logic [63:0] data;
    logic        de;
    logic        busy;

    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1, is_tran, data, de, busy
    );

    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1, is_tran, data, de, busy
    );
endinterface

`default_nettype wire

// File: rtl/hdlc_tx_sched.sv
// ============================================================================
// Module      : hdlc_tx_sched
// Description : Round-robin scheduler for two frame sources that share one
//               64-bit HDLC serializer on an RS-485 link. It latches the
//               winning frame, applies pre/post driver-enable guard times and
//               holds the link busy through the serialization window.
//               Optional macro HDLC_SCHED_KEEPALIVE_EN adds an idle-frame
//               keepalive after KEEPALIVE request-free idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlc_tx_sched #(
    parameter int GUARD_PRE    = 4,
    parameter int GUARD_POST   = 4,
    parameter int FRAME_CYCLES = 66,
    parameter int KEEPALIVE    = 9600
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hdlc_tx_sched_if.slave   bus
);

    localparam logic [63:0] c_idle_frame = 64'h7E0001000037307E;
    localparam logic [15:0] c_pre_last   = 16'(GUARD_PRE - 1);
    localparam logic [15:0] c_send_last  = 16'(FRAME_CYCLES - 1);
    localparam logic [15:0] c_post_last  = 16'(GUARD_POST - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_POST = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_rr;
    logic        r_gid;
    logic        r_ka;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_is_tran;
    logic [63:0] r_data;
    logic        r_de;
    logic        r_busy;
    logic        w_pick;

`ifdef HDLC_SCHED_KEEPALIVE_EN
    localparam logic [15:0] c_ka_last = 16'(KEEPALIVE - 1);
    logic [15:0] r_idle_cnt;
`else
    // KEEPALIVE only matters when the keepalive option is built in.
    logic w_unused_ka;
    assign w_unused_ka = (KEEPALIVE == 0);
`endif

    // Arbitration: a lone requester wins; on contention the rr pointer decides.
    always_comb begin
        w_pick = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_pick = r_rr;
        end else begin
            w_pick = bus.req1;
        end
    end

    // Scheduler FSM with registered outputs; async reset drops de at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_rr      <= 1'b0;
            r_gid     <= 1'b0;
            r_ka      <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_is_tran <= 1'b0;
            r_data    <= c_idle_frame;
            r_de      <= 1'b0;
            r_busy    <= 1'b0;
`ifdef HDLC_SCHED_KEEPALIVE_EN
            r_idle_cnt <= 16'd0;
`endif
        end else begin
            // Strobes last exactly one cycle unless re-armed below.
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_is_tran <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_state <= S_PRE;
                        r_cnt   <= 16'd0;
                        r_de    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_gid   <= w_pick;
                        r_ka    <= 1'b0;
                        r_data  <= w_pick ? bus.data1 : bus.data0;
`ifdef HDLC_SCHED_KEEPALIVE_EN
                        r_idle_cnt <= 16'd0;
                    end else if (r_idle_cnt == c_ka_last) begin
                        // Keepalive: idle frame, no ack, rr pointer untouched.
                        r_state    <= S_PRE;
                        r_cnt      <= 16'd0;
                        r_de       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ka       <= 1'b1;
                        r_data     <= c_idle_frame;
                        r_idle_cnt <= 16'd0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
`endif
                    end
                end
                S_PRE: begin
                    if (r_cnt == c_pre_last) begin
                        r_state   <= S_LOAD;
                        r_cnt     <= 16'd0;
                        r_is_tran <= 1'b1;
                        r_ack0    <= ~r_ka & ~r_gid;
                        r_ack1    <= ~r_ka & r_gid;
                        if (!r_ka) begin
                            r_rr <= ~r_gid;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SEND;
                    r_cnt   <= 16'd0;
                end
                S_SEND: begin
                    if (r_cnt == c_send_last) begin
                        r_state <= S_POST;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_POST: begin
                    if (r_cnt == c_post_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                        r_de    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ka    <= 1'b0;
                        r_data  <= c_idle_frame;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0    = r_ack0;
    assign bus.ack1    = r_ack1;
    assign bus.is_tran = r_is_tran;
    assign bus.data    = r_data;
    assign bus.de      = r_de;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_tx_sched.sv
// ============================================================================
// Module      : tb_hdlc_tx_sched
// Description : Directed self-checking bench for hdlc_tx_sched (default
//               timing parameters, KEEPALIVE overridden to 100).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hdlc_tx_sched;

    localparam logic [63:0] c_idle = 64'h7E0001000037307E;
    localparam logic [63:0] c_f0   = 64'h7E0102030405067E;
    localparam logic [63:0] c_f1   = 64'h7E1112131415167E;
    localparam logic [63:0] c_f2   = 64'h7E2122232425267E;
    localparam int          c_ka   = 100;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_both;
    int   ack_q[$];

    hdlc_tx_sched_if bus ();

    hdlc_tx_sched #(
        .GUARD_PRE    (4),
        .GUARD_POST   (4),
        .FRAME_CYCLES (66),
        .KEEPALIVE    (c_ka)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ack order log and dual-ack detector, sampled mid-cycle.
    initial n_both = 0;
    always @(negedge clk) begin
        if (bus.ack0 && bus.ack1) n_both++;
        if (bus.ack0) ack_q.push_back(0);
        if (bus.ack1) ack_q.push_back(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until is_tran is seen or the bound expires; n = steps taken.
    task automatic wait_tran(input int max, output int n);
        n = 0;
        while (!bus.is_tran && n < max) begin
            step();
            n++;
        end
    endtask

    // Hold reset over two edges, release mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;

        // Reset values
        step();
        check("rst_de", bus.de, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_is_tran", bus.is_tran, 0);
        check("rst_ack0", bus.ack0, 0);
        check("rst_ack1", bus.ack1, 0);
        check("rst_data", bus.data, c_idle);

        // Single request: latency, frame, guard times
        do_reset();
        bus.req0 = 1'b1;
        bus.data0 = c_f0;
        step();
        check("t1_de_on", bus.de, 1);
        check("t1_busy_on", bus.busy, 1);
        check("t1_data_latched", bus.data, c_f0);
        wait_tran(20, n);
        check("t1_latency", 1 + n, 5);
        check("t1_ack0", bus.ack0, 1);
        check("t1_ack1", bus.ack1, 0);
        check("t1_data", bus.data, c_f0);
        bus.req0 = 1'b0;
        step();
        check("t1_tran_drop", bus.is_tran, 0);
        check("t1_ack_drop", bus.ack0, 0);
        for (int i = 0; i < 65 + 4; i++) step();
        check("t1_de_post_end", bus.de, 1);
        check("t1_busy_post_end", bus.busy, 1);
        check("t1_data_hold", bus.data, c_f0);
        step();
        check("t1_de_off", bus.de, 0);
        check("t1_busy_off", bus.busy, 0);
        check("t1_data_idle", bus.data, c_idle);

        // Simultaneous requests: 0 first after reset, then 1
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.data0 = c_f0;
        bus.data1 = c_f1;
        wait_tran(20, n);
        check("t2_lat0", n, 5);
        check("t2_ack0", bus.ack0, 1);
        check("t2_data0", bus.data, c_f0);
        bus.req0 = 1'b0;
        step();
        wait_tran(200, n);
        check("t2_gap", 1 + n, 76);
        check("t2_ack1", bus.ack1, 1);
        check("t2_data1", bus.data, c_f1);
        bus.req1 = 1'b0;

        // Continuous contention: alternation and spacing
        do_reset();
        base = ack_q.size();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        wait_tran(20, n);
        check("t3_lat", n, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            wait_tran(200, n);
            check("t3_gap", 1 + n, 76);
        end
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("t3_nacks", ack_q.size() - base, 4);
        if (ack_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", ack_q[base + i], i % 2);
        end

        // Reset during SEND, then held req1 served normally
        do_reset();
        bus.req1 = 1'b1;
        bus.data1 = c_f1;
        wait_tran(20, n);
        check("t4_lat", n, 5);
        for (int i = 0; i < 20; i++) step();
        check("t4_busy_send", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t4_de_async", bus.de, 0);
        check("t4_busy_async", bus.busy, 0);
        step();
        check("t4_no_ack_a", bus.ack1, 0);
        step();
        check("t4_no_ack_b", bus.ack1, 0);
        check("t4_no_tran", bus.is_tran, 0);
        #2 rst = 1'b0;
        wait_tran(20, n);
        check("t4_relat", n, 5);
        check("t4_reack", bus.ack1, 1);
        bus.req1 = 1'b0;

        // One-cycle request pulse is still served and acked
        do_reset();
        step();
        bus.req1 = 1'b1;
        bus.data1 = c_f2;
        step();
        bus.req1 = 1'b0;
        check("t6_busy", bus.busy, 1);
        wait_tran(20, n);
        check("t6_lat", 1 + n, 5);
        check("t6_ack1", bus.ack1, 1);
        check("t6_data", bus.data, c_f2);

`ifdef HDLC_SCHED_KEEPALIVE_EN
        // Keepalive frame, then a request at the trigger cycle wins
        do_reset();
        base = ack_q.size();
        wait_tran(300, n);
        check("t5_ka_lat", n, c_ka + 4);
        check("t5_ka_data", bus.data, c_idle);
        check("t5_ka_ack0", bus.ack0, 0);
        check("t5_ka_ack1", bus.ack1, 0);
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        check("t5_ka_done", bus.busy, 0);
        for (int i = 0; i < c_ka - 1; i++) step();
        check("t5_pre_busy", bus.busy, 0);
        check("t5_ka_noack", ack_q.size() - base, 0);
        bus.req1 = 1'b1;
        bus.data1 = c_f1;
        wait_tran(20, n);
        check("t5_req_lat", n, 5);
        check("t5_req_ack1", bus.ack1, 1);
        check("t5_req_data", bus.data, c_f1);
        bus.req1 = 1'b0;
`else
        // Without keepalive, an idle link stays silent
        do_reset();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus.is_tran || bus.de) n++;
        end
        check("t5_idle_silent", n, 0);
`endif

        step();
        check("no_dual_ack", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
